// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial memory controller arbitrating an instruction fetch
//             port and a load/store port onto a single 8-bit synchronous RAM.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IF_RD  = 2'd1,
        S_MEM_RD = 2'd2,
        S_MEM_WR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;          // byte index being captured / written
    logic        wait_q, wait_d;        // first read cycle: RAM data not yet valid
    logic [1:0]  len_q, len_d;          // transfer size code (fetch uses word)
    logic [31:0] buf_q, buf_d;          // partial read assembly
    logic [31:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [2:0]  w_n;
    logic        w_last;
    logic [1:0]  w_cnt_inc;
    logic [31:0] w_merged;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Datapath helpers: byte count, last-byte flag and read word with current byte merged in
    always_comb begin
        w_n       = len_to_n(len_q);
        w_last    = ({1'b0, cnt_q} == (w_n - 3'd1));
        w_cnt_inc = cnt_q + 2'd1;
        w_merged  = buf_q;
        w_merged[{cnt_q, 3'b000} +: 8] = ram_din;
    end

    // Next-state and register-update logic for arbitration and byte sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        len_d       = len_q;
        buf_d       = buf_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_d        = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            S_IDLE: begin
                // A done pulse marks the turnaround cycle: requesters are still
                // dropping their request, so nothing is accepted on this edge.
                if (!if_done_q && !mem_done_q) begin
                    if (mem_req) begin
                        state_d = mem_we ? S_MEM_WR : S_MEM_RD;
                        len_d   = mem_len;
                        cnt_d   = 2'd0;
                        wait_d  = 1'b1;
                        buf_d   = 32'd0;
                        addr_d  = mem_addr;
                        if (mem_we) begin
                            dout_d = mem_wdata[7:0];
                            wr_d   = 1'b1;
                        end
                    end else if (if_req && !if_flush) begin
                        state_d = S_IF_RD;
                        len_d   = 2'b10;
                        cnt_d   = 2'd0;
                        wait_d  = 1'b1;
                        buf_d   = 32'd0;
                        addr_d  = if_addr;
                    end
                end
            end

            S_IF_RD, S_MEM_RD: begin
                if (state_q == S_IF_RD && if_flush) begin
                    state_d = S_IDLE;
                end else if (wait_q) begin
                    wait_d = 1'b0;
                    if (w_n > 3'd1) begin
                        addr_d = addr_q + 32'd1;
                    end
                end else begin
                    buf_d = w_merged;
                    if (w_last) begin
                        state_d = S_IDLE;
                        if (state_q == S_IF_RD) begin
                            if_inst_d = w_merged;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = w_merged;
                            mem_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = w_cnt_inc;
                        // The address runs two bytes ahead of the capture index.
                        if (({1'b0, cnt_q} + 3'd2) < w_n) begin
                            addr_d = addr_q + 32'd1;
                        end
                    end
                end
            end

            S_MEM_WR: begin
                if (w_last) begin
                    state_d    = S_IDLE;
                    mem_done_d = 1'b1;
                end else begin
                    wr_d   = 1'b1;
                    cnt_d  = w_cnt_inc;
                    addr_d = addr_q + 32'd1;
                    dout_d = mem_wdata[{w_cnt_inc, 3'b000} +: 8];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register: reset wins over rdy; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            wait_q      <= 1'b0;
            len_q       <= 2'd0;
            buf_q       <= 32'd0;
            addr_q      <= 32'd0;
            dout_q      <= 8'd0;
            wr_q        <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Write strobe is suppressed while frozen so a stalled store never repeats
    assign ram_wr    = wr_q & rdy;
    assign ram_addr  = addr_q;
    assign ram_dout  = dout_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: rdy  in  1  global enable; low freezes block.
REQ-004 SHALL have: if_req  in  1  fetch request, level, held until if_done.
REQ-005 SHALL have: if_addr  in  32  fetch byte address.
REQ-006 SHALL have: if_flush  in  1  abort in-flight fetch (redirect).
REQ-007 SHALL have: if_done  out  1  one-cycle pulse, if_inst valid.
REQ-008 SHALL have: if_inst  out  32  fetched word, little-endian.
REQ-009 SHALL have: mem_req  in  1  load/store request, level, held until mem_done.
REQ-010 SHALL have: mem_we  in  1  1=store, 0=load.
REQ-011 SHALL have: mem_len  in  2  00=byte, 01=half, 10/11=word.
REQ-012 SHALL have: mem_addr  in  32  data byte address.
REQ-013 SHALL have: mem_wdata  in  32  store data, low bytes used.
REQ-014 SHALL have: mem_done  out  1  one-cycle pulse, transaction complete.
REQ-015 SHALL have: mem_rdata  out  32  load data, unused upper bytes zero (sign extension downstream).
REQ-016 SHALL have: ram_din  in  8  RAM read byte.
REQ-017 SHALL have: ram_dout  out  8  RAM write byte.
REQ-018 SHALL have: ram_addr  out  32  RAM byte address.
REQ-019 SHALL have: ram_wr  out  1  1=write, 0=read.
REQ-020 SHALL have: busy  out  1  high in any non-IDLE state.

Function
REQ-021 RAM model: address registered at edge e, ram_din valid after edge e+1; write committed at edge e+1 when ram_wr=1.
REQ-022 States SHALL be IDLE, IF_RD, MEM_RD, MEM_WR; byte counter 0..3; N = 1/2/4 from mem_len, 4 for fetch.
REQ-023 IDLE arbitration: mem_req wins over if_req; if_req alone -> IF_RD; none -> stay IDLE.
REQ-024 No preemption: an accepted transaction runs to completion except fetch abort per REQ-030.
REQ-025 Accept at edge k: byte i address (base+i, mod 2^32) SHALL drive ram_addr from edge k+i, i=0..N-1.
REQ-026 Read: byte i captured at edge k+i+2 into bits [8i+7:8i]; done set at edge k+N+1.
REQ-027 Write: ram_wr=1, ram_dout=mem_wdata[8i+7:8i] from edge k+i; mem_done set at edge k+N; ram_wr=0 from edge k+N.
REQ-028 ram_wr SHALL be 0 in all states other than MEM_WR; ram_addr holds last value when idle.
REQ-029 Done pulse coincides with return to IDLE; requests SHALL be ignored during that cycle (one turnaround cycle), arbitration resumes next edge.
REQ-030 if_flush high at an edge in IF_RD -> IDLE at that edge, no if_done, partial data discarded; if_flush in IDLE blocks fetch acceptance that edge; ignored in MEM states.
REQ-031 if_inst/mem_rdata SHALL hold value until next completing transaction of same type.
REQ-032 rdy=0: state, counter, outputs hold; ram_wr forced 0; done pulses not generated; resumes unchanged when rdy=1 (RAM side tolerates repeated address).

Reset
REQ-033 rst=1 at edge: state IDLE, counter 0, if_done=mem_done=0, if_inst=mem_rdata=0, ram_addr=0, ram_dout=0, ram_wr=0, busy=0.
REQ-034 rst mid-transaction SHALL abandon it with no done pulse; rst takes priority over rdy.

Verification
REQ-035 Fetch: if_req, if_addr=0x100, RAM bytes 13,05,00,00 -> if_done 5 edges after accept, if_inst=0x00000513.
REQ-036 Simultaneous if_req+mem_req (load word 0x200) -> MEM_RD first, mem_done, turnaround, then IF_RD.
REQ-037 Store half 0x1234 at 0x3 -> ram_wr=1 two cycles, addresses 0x3,0x4, data 0x34,0x12; mem_done 2 edges after accept.
REQ-038 Load byte 0xFF at 0x10 -> mem_rdata=0x000000FF, done 2 edges after accept.
REQ-039 if_flush at second byte of fetch -> IDLE, no if_done; new fetch 0x200 completes normally.
REQ-040 Fetch at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1; rdy dropped 3 cycles mid-read -> same result, delayed 3 cycles.
